// File: rtl/ascii_display_ctrl_pkg.sv
// Shared constants for the ASCII scrolling display controller and its decoder.
package ascii_display_ctrl_pkg;

  localparam logic [7:0] ASCII_SPACE = 8'h20;
  localparam logic [7:0] ASCII_BS    = 8'h08;
  localparam logic [7:0] ASCII_CR    = 8'h0D;
  localparam logic [7:0] ASCII_LF    = 8'h0A;
  localparam logic [7:0] PRINT_MIN   = 8'h20;
  localparam logic [7:0] PRINT_MAX   = 8'h7E;
  localparam logic [6:0] SEG_BLANK   = 7'h7F;

  function automatic logic is_printable(input logic [7:0] c);
    return (c >= PRINT_MIN) && (c <= PRINT_MAX);
  endfunction

endpackage

// File: rtl/ascii_to_7_segment.sv
// Combinational ASCII to active-low 7-segment decoder, bit order {g,f,e,d,c,b,a}.
module ascii_to_7_segment
  import ascii_display_ctrl_pkg::*;
(
  input  logic [7:0] ascii,
  output logic [6:0] seg_c
);

  // Hex digits only; anything unmapped (space included) goes dark.
  always_comb begin
    seg_c = SEG_BLANK;
    case (ascii)
      8'h30: seg_c = 7'b1000000;
      8'h31: seg_c = 7'b1111001;
      8'h32: seg_c = 7'b0100100;
      8'h33: seg_c = 7'b0110000;
      8'h34: seg_c = 7'b0011001;
      8'h35: seg_c = 7'b0010010;
      8'h36: seg_c = 7'b0000010;
      8'h37: seg_c = 7'b1111000;
      8'h38: seg_c = 7'b0000000;
      8'h39: seg_c = 7'b0010000;
      8'h41, 8'h61: seg_c = 7'b0001000;
      8'h42, 8'h62: seg_c = 7'b0000011;
      8'h43, 8'h63: seg_c = 7'b1000110;
      8'h44, 8'h64: seg_c = 7'b0100001;
      8'h45, 8'h65: seg_c = 7'b0000110;
      8'h46, 8'h66: seg_c = 7'b0001110;
      default: seg_c = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/ascii_display_ctrl.sv
// Scrolling character buffer fed by UART bytes, scanned onto a multiplexed
// active-low 7-segment display through one shared decoder.
module ascii_display_ctrl
  import ascii_display_ctrl_pkg::*;
#(
  parameter int unsigned NUM_DIGITS  = 4,
  parameter int unsigned REFRESH_DIV = 50000
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic [7:0]                        rx_data,
  input  logic                              rx_valid,
  output logic [6:0]                        seg,
  output logic [NUM_DIGITS-1:0]             digit_en,
  output logic [$clog2(NUM_DIGITS+1)-1:0]   char_count
);

  localparam int unsigned CNT_W = $clog2(NUM_DIGITS + 1);
  localparam int unsigned IDX_W = $clog2(NUM_DIGITS);
  localparam int unsigned DIV_W = $clog2(REFRESH_DIV);

  logic [7:0]       chars     [NUM_DIGITS];
  logic [7:0]       chars_nxt [NUM_DIGITS];
  logic [CNT_W-1:0] count_nxt;
  logic [DIV_W-1:0] refresh_cnt;
  logic [IDX_W-1:0] scan_idx;
  logic [7:0]       scan_char_c;
  logic [6:0]       seg_dec_c;

  // Next buffer contents for the received control or printable byte.
  always_comb begin
    chars_nxt = chars;
    count_nxt = char_count;
    if (rx_valid) begin
      if (is_printable(rx_data)) begin
        for (int i = NUM_DIGITS - 1; i >= 1; i--) chars_nxt[i] = chars[i-1];
        chars_nxt[0] = rx_data;
        if (char_count != CNT_W'(NUM_DIGITS)) count_nxt = char_count + CNT_W'(1);
      end else if (rx_data == ASCII_BS) begin
        if (char_count != '0) begin
          for (int i = 0; i < NUM_DIGITS - 1; i++) chars_nxt[i] = chars[i+1];
          chars_nxt[NUM_DIGITS-1] = ASCII_SPACE;
          count_nxt = char_count - CNT_W'(1);
        end
      end else if ((rx_data == ASCII_CR) || (rx_data == ASCII_LF)) begin
        for (int i = 0; i < NUM_DIGITS; i++) chars_nxt[i] = ASCII_SPACE;
        count_nxt = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_DIGITS; i++) chars[i] <= ASCII_SPACE;
      char_count <= '0;
    end else begin
      chars      <= chars_nxt;
      char_count <= count_nxt;
    end
  end

  // Refresh timer; the scan moves to the next digit on the last tick of each window.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      refresh_cnt <= '0;
      scan_idx    <= '0;
    end else if (refresh_cnt == DIV_W'(REFRESH_DIV - 1)) begin
      refresh_cnt <= '0;
      scan_idx    <= (scan_idx == IDX_W'(NUM_DIGITS - 1)) ? '0 : scan_idx + IDX_W'(1);
    end else begin
      refresh_cnt <= refresh_cnt + DIV_W'(1);
    end
  end

  assign scan_char_c = chars[scan_idx];

  ascii_to_7_segment u_dec (
    .ascii (scan_char_c),
    .seg_c (seg_dec_c)
  );

  // seg and digit_en share one register stage so they switch together.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      seg      <= SEG_BLANK;
      digit_en <= '1;
    end else begin
      seg      <= seg_dec_c;
      digit_en <= ~(NUM_DIGITS'(1) << scan_idx);
    end
  end

endmodule

// File: tb/tb_ascii_display_ctrl.sv
// Directed bench for ascii_display_ctrl with a 4-digit display and a short refresh window.
module tb_ascii_display_ctrl;

  logic       clk;
  logic       rst_n;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic [6:0] seg;
  logic [3:0] digit_en;
  logic [2:0] char_count;

  int n_checks;
  int n_fail;

  ascii_display_ctrl #(.NUM_DIGITS(4), .REFRESH_DIV(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .seg        (seg),
    .digit_en   (digit_en),
    .char_count (char_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    tick();
    rx_valid = 1'b0;
    rx_data  = 8'h00;
  endtask

  // Advance at least one cycle, then until digit d is the enabled one.
  task automatic wait_digit(input int d);
    logic [3:0] tgt;
    bit found;
    tgt = ~(4'b0001 << d);
    found = 1'b0;
    for (int k = 0; k < 40 && !found; k++) begin
      tick();
      if (digit_en === tgt) found = 1'b1;
    end
    if (!found) begin
      n_checks++;
      n_fail++;
      $error("FAIL wait_digit%0d: observed %h expected %h", d, digit_en, tgt);
    end
  endtask

  task automatic chk_digit(input int d, input logic [6:0] exp_seg, input string tag);
    wait_digit(d);
    chk(tag, 32'(seg), 32'(exp_seg));
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst_n    = 1'b0;
    rx_valid = 1'b0;
    rx_data  = 8'h00;

    // Reset
    tick(); tick(); tick();
    chk("rst_seg", 32'(seg), 32'h7F);
    chk("rst_den", 32'(digit_en), 32'hF);
    chk("rst_cnt", 32'(char_count), 32'd0);
    rst_n = 1'b1;
    tick();
    chk("first_den", 32'(digit_en), 32'hE);
    chk("first_seg", 32'(seg), 32'h7F);
    chk_digit(1, 7'h7F, "rst_d1");
    chk("rst_den1", 32'(digit_en), 32'hD);
    chk_digit(2, 7'h7F, "rst_d2");
    chk("rst_den2", 32'(digit_en), 32'hB);
    chk_digit(3, 7'h7F, "rst_d3");
    chk("rst_den3", 32'(digit_en), 32'h7);

    // Shift-in "123"
    send(8'h31); send(8'h32); send(8'h33);
    chk("shift_cnt", 32'(char_count), 32'd3);
    chk_digit(0, 7'b0110000, "shift_d0");
    chk_digit(1, 7'b0100100, "shift_d1");
    chk_digit(2, 7'b1111001, "shift_d2");
    chk_digit(3, 7'h7F,      "shift_d3");

    // Overflow "012345" -> "2345"
    for (int i = 0; i < 6; i++) send(8'(8'h30 + i));
    chk("ovf_cnt", 32'(char_count), 32'd4);
    chk_digit(0, 7'b0010010, "ovf_d0");
    chk_digit(1, 7'b0011001, "ovf_d1");
    chk_digit(2, 7'b0110000, "ovf_d2");
    chk_digit(3, 7'b0100100, "ovf_d3");

    // Backspace from "ABCD"
    send(8'h41); send(8'h42); send(8'h43); send(8'h44);
    send(8'h08);
    chk("bs1_cnt", 32'(char_count), 32'd3);
    chk_digit(0, 7'b1000110, "bs1_d0");
    chk_digit(1, 7'b0000011, "bs1_d1");
    chk_digit(2, 7'b0001000, "bs1_d2");
    chk_digit(3, 7'h7F,      "bs1_d3");
    for (int i = 0; i < 5; i++) send(8'h08);
    chk("bs6_cnt", 32'(char_count), 32'd0);
    chk_digit(0, 7'h7F, "bs6_d0");
    chk_digit(2, 7'h7F, "bs6_d2");
    send(8'h31);
    chk("bs_recover_cnt", 32'(char_count), 32'd1);
    chk_digit(0, 7'b1111001, "bs_recover_d0");

    // Ignore codes, then clear
    send(8'h0D);
    send(8'h41); send(8'h42); send(8'h43); send(8'h44);
    send(8'h07);
    send(8'h7F);
    send(8'hC5);
    chk("ign_cnt", 32'(char_count), 32'd4);
    chk_digit(0, 7'b0100001, "ign_d0");
    chk_digit(3, 7'b0001000, "ign_d3");
    send(8'h0D);
    chk("cr_cnt", 32'(char_count), 32'd0);
    chk_digit(0, 7'h7F, "cr_d0");
    chk_digit(1, 7'h7F, "cr_d1");
    chk_digit(2, 7'h7F, "cr_d2");
    chk_digit(3, 7'h7F, "cr_d3");
    send(8'h31); send(8'h32);
    send(8'h0A);
    chk("lf_cnt", 32'(char_count), 32'd0);
    chk_digit(0, 7'h7F, "lf_d0");

    // Reset on the same edge as a received 'E'
    send(8'h31); send(8'h32);
    rst_n    = 1'b0;
    rx_valid = 1'b1;
    rx_data  = 8'h45;
    tick();
    rst_n    = 1'b1;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    chk("mrst_cnt", 32'(char_count), 32'd0);
    chk("mrst_seg", 32'(seg), 32'h7F);
    chk("mrst_den", 32'(digit_en), 32'hF);
    tick();
    chk("mrst_den0", 32'(digit_en), 32'hE);
    chk("mrst_seg0", 32'(seg), 32'h7F);
    chk_digit(1, 7'h7F, "mrst_d1");

    // 'F' arrives while digit 0 is being sampled
    send(8'h38);
    wait_digit(3);
    wait_digit(0);
    rx_data  = 8'h46;
    rx_valid = 1'b1;
    tick();
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    chk("haz_old_seg", 32'(seg), 32'h00);
    chk("haz_old_den", 32'(digit_en), 32'hE);
    tick();
    chk("haz_new_seg", 32'(seg), 32'(7'b0001110));
    chk("haz_new_den", 32'(digit_en), 32'hE);
    chk("haz_cnt", 32'(char_count), 32'd2);
    chk_digit(1, 7'b0000000, "haz_d1");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
